// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_fifo
// Description : Captures each received UART byte once, on the rising edge of
//               rx_Done, into a circular FIFO. Bytes are popped through a
//               registered read port. A sticky flag records dropped bytes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              d_Clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_Data,
  input  logic              rx_Done,
  input  logic              rd_En,
  input  logic              ovf_Clr,
  output logic [DATA_W-1:0] rd_Data,
  output logic              rd_Valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_done_d;

  logic w_wr_stb;
  logic w_do_wr;
  logic w_do_rd;
  logic w_drop;

  // rx_Done stays high for the whole stop phase; only its rising edge writes.
  assign w_wr_stb = rx_Done & ~r_done_d;
  assign w_do_rd  = rd_En & ~empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_wr  = w_wr_stb & (~full | rd_En);
  assign w_drop   = w_wr_stb & full & ~rd_En;

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == c_DEPTH);

  always_ff @(posedge d_Clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= rx_Data;
    end
  end

  always_ff @(posedge d_Clk or negedge reset) begin
    if (!reset) begin
      r_done_d <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      rd_Data  <= '0;
      rd_Valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_done_d <= rx_Done;

      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // The read sees mem before this edge's write, so a full FIFO returns
      // its oldest entry and an empty FIFO never bypasses the new byte.
      if (w_do_rd) begin
        rd_Data  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
        rd_Valid <= 1'b1;
      end else begin
        rd_Valid <= 1'b0;
      end

      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_drop) begin
        overflow <= 1'b1;
      end else if (ovf_Clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

  logic       d_Clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_Data = 8'h00;
  logic       rx_Done = 1'b0;
  logic       rd_En = 1'b0;
  logic       ovf_Clr = 1'b0;
  logic [7:0] rd_Data;
  logic       rd_Valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  uart_rx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
    .d_Clk    (d_Clk),
    .reset    (reset),
    .rx_Data  (rx_Data),
    .rx_Done  (rx_Done),
    .rd_En    (rd_En),
    .ovf_Clr  (ovf_Clr),
    .rd_Data  (rd_Data),
    .rd_Valid (rd_Valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 d_Clk = ~d_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge d_Clk);
    @(negedge d_Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_Data = b;
    rx_Done = 1'b1;
    repeat (2) tick();
    rx_Done = 1'b0;
    tick();
  endtask

  task automatic read_one(input string tag, input logic [7:0] exp);
    rd_En = 1'b1;
    tick();
    rd_En = 1'b0;
    check({tag, "_valid"}, 32'(rd_Valid), 32'd1);
    check({tag, "_data"}, 32'(rd_Data), 32'(exp));
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_valid", 32'(rd_Valid), 32'd0);
    check("rst_data", 32'(rd_Data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge d_Clk);
    reset = 1'b1;
    tick();

    // 1: a 16-cycle rx_Done pulse writes exactly once, on its first cycle
    rx_Data = 8'hA5;
    rx_Done = 1'b1;
    tick();
    check("t1_count_1cyc", 32'(count), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    repeat (15) tick();
    rx_Done = 1'b0;
    tick();
    check("t1_count_16cyc", 32'(count), 32'd1);
    read_one("t1_rd", 8'hA5);
    check("t1_count_after", 32'(count), 32'd0);
    check("t1_empty_after", 32'(empty), 32'd1);
    tick();
    check("t1_valid_drop", 32'(rd_Valid), 32'd0);

    // 2: fill, overflow drop, drain in order
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_count16", 32'(count), 32'd16);
    check("t2_ovf_pre", 32'(overflow), 32'd0);
    send_byte(8'hFF);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_count_drop", 32'(count), 32'd16);
    rd_En = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t2_drain_valid", 32'(rd_Valid), 32'd1);
      check("t2_drain_data", 32'(rd_Data), 32'(i));
    end
    rd_En = 1'b0;
    tick();
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_valid_off", 32'(rd_Valid), 32'd0);

    // 3: pointer wrap across index 15 -> 0
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i));
    for (int i = 0; i < 10; i++) read_one("t3_pre", 8'h80 + 8'(i));
    for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i));
    check("t3_count12", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) read_one("t3_wrap", 8'h20 + 8'(i));
    check("t3_empty", 32'(empty), 32'd1);

    // Clear sticky overflow left from test 2
    ovf_Clr = 1'b1;
    tick();
    ovf_Clr = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // 4: full FIFO, write and read in the same cycle
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
    check("t4_full", 32'(full), 32'd1);
    rx_Data = 8'h77;
    rx_Done = 1'b1;
    rd_En   = 1'b1;
    tick();
    rd_En = 1'b0;
    check("t4_valid", 32'(rd_Valid), 32'd1);
    check("t4_oldest", 32'(rd_Data), 32'h40);
    check("t4_count", 32'(count), 32'd16);
    check("t4_ovf", 32'(overflow), 32'd0);
    tick();
    rx_Done = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) read_one("t4_drain", 8'h40 + 8'(i));
    read_one("t4_last", 8'h77);
    check("t4_empty", 32'(empty), 32'd1);

    // 5: empty FIFO, write and read together -> no bypass
    rx_Data = 8'h3C;
    rx_Done = 1'b1;
    rd_En   = 1'b1;
    tick();
    rd_En   = 1'b0;
    rx_Done = 1'b0;
    check("t5_no_bypass", 32'(rd_Valid), 32'd0);
    check("t5_count1", 32'(count), 32'd1);
    tick();
    read_one("t5_rd", 8'h3C);

    // 5b: overflow set beats a same-cycle clear; clear alone then works
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
    rx_Data = 8'h99;
    rx_Done = 1'b1;
    ovf_Clr = 1'b1;
    tick();
    rx_Done = 1'b0;
    ovf_Clr = 1'b0;
    check("t5_set_wins", 32'(overflow), 32'd1);
    tick();
    ovf_Clr = 1'b1;
    tick();
    ovf_Clr = 1'b0;
    check("t5_clr_alone", 32'(overflow), 32'd0);
    check("t5_clr_keeps_data", 32'(count), 32'd16);
    send_byte(8'h9A);
    check("t5_ovf_again", 32'(overflow), 32'd1);
    rd_En = 1'b1;
    repeat (16) tick();
    rd_En = 1'b0;
    check("t5_drain_last", 32'(rd_Data), 32'h6F);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) send_byte(8'hD0 + 8'(i));
    check("t6_count5", 32'(count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_data", 32'(rd_Data), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_no_valid", 32'(rd_Valid), 32'd0);
    send_byte(8'h5A);
    check("t6_count_one", 32'(count), 32'd1);
    read_one("t6_rd", 8'h5A);
    check("t6_empty_end", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

`default_nettype wire
